soc_bus_fabric: RTL and testbench
=================================

# soc_bus_fabric

Parametrised memory-bus fabric that sits between the PicoRV32 native memory port and up to NUM_SLAVES memory-mapped targets (SRAM, peripherals). It replaces the single CPU-to-SRAM point-to-point wiring with an address decoder, one-outstanding-transaction FSM, per-access timeout, and an error responder. The error responder completes unmapped or hung accesses so the CPU never stalls forever.

## Interface
- NUM_SLAVES, 4, number of targets (1..16)
- SLAVE_BASE, {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}, packed NUM_SLAVES×32 base addresses; slave i at bits [32i+31:32i]
- SLAVE_MASK, {4{32'hFFFF_0000}}, packed NUM_SLAVES×32 masks; slave i hits when (m_addr & MASK_i) == BASE_i
- TIMEOUT_CYCLES, 255, max cycles a slave may hold an access; 0 disables timeout
- ERR_RDATA, 32'hBADA_DD00, read data returned on error completion

Ports:
- clk  in  1  system clock, all logic on rising edge
- resetn  in  1  synchronous reset, active-low
- m_valid, m_instr  in  1 each  CPU request, instruction-fetch flag (m_instr unused internally)
- m_addr, m_wdata  in  32 each  CPU byte address, write data
- m_wstrb  in  4  byte enables; 0 = read
- m_ready  out  1  access complete (single-cycle pulse)
- m_rdata  out  32  read data, valid when m_ready=1, else 0
- s_valid  out  NUM_SLAVES  one-hot request to selected slave
- s_addr, s_wdata  out  32 each  broadcast copies of m_addr, m_wdata
- s_wstrb  out  4  broadcast copy of m_wstrb
- s_rdata  in  NUM_SLAVES×32  slave read data, slave i at [32i+31:32i]
- s_ready  in  NUM_SLAVES  slave completion
- err_pulse  out  1  one-cycle pulse on every error completion
- err_addr  out  32  address of last errored access
- err_count  out  16  saturating error count

## Operation
- States: IDLE, ACCESS, ERROR, GAP.
- IDLE with m_valid=1: decode m_addr; lowest-index hit wins. Hit: latch sel, clear timeout counter, go ACCESS. Miss: go ERROR.
- ACCESS: s_valid[sel]=1; all other s_valid bits 0.
  - s_ready[sel]=1: m_ready=1 and m_rdata=s_rdata[sel] in the same cycle (combinational pass-through); next state GAP.
  - Otherwise counter increments. If TIMEOUT_CYCLES≠0 and counter reaches TIMEOUT_CYCLES-1 without ready, next state ERROR.
  - s_ready of non-selected slaves is ignored.
- ERROR (one cycle): s_valid all 0; m_ready=1; m_rdata=ERR_RDATA for reads, 0 for writes (write discarded).
  - err_pulse=1; err_addr<=m_addr; err_count increments, saturating at 16'hFFFF.
  - Next state GAP.
- GAP (one cycle): ignores m_valid, which lets the CPU deassert its request; next state IDLE.
- m_valid dropping during ACCESS is a protocol abort: s_valid drops next cycle, no m_ready, state goes to IDLE, no error is logged.
- Simultaneous s_ready and timeout expiry in the same cycle: ready wins, no error.
- s_addr/s_wdata/s_wstrb are always combinational copies of the m_* inputs.

## Timing
- Reset (resetn=0 at a clock edge): state=IDLE, counter=0, sel=0, err_addr=0, err_count=0. Outputs s_valid=0, m_ready=0, m_rdata=0, err_pulse=0 from that edge on.
- Reset mid-access drops s_valid on the next edge with no m_ready.
- Cycle numbering below: m_valid first seen high in IDLE at cycle T.
  - Hit: s_valid from T+1. For a slave with ready in its first cycle, m_ready at T+1. For an L-cycle slave, m_ready at T+L.
  - Miss: m_ready and err_pulse at T+1.
  - Timeout: s_valid high T+1..T+TIMEOUT_CYCLES; m_ready and err_pulse at T+TIMEOUT_CYCLES+1.
- Minimum back-to-back spacing: next request accepted in IDLE two cycles after m_ready.
- err_addr and err_count update on the edge ending the ERROR cycle.

## Test plan
- Map slave0 0x0000_0000/0xFFFF_0000; read 0x0000_0010 with zero-wait slave returning 0x1234_5678 -> s_valid=4'b0001 at T+1, m_ready at T+1 with m_rdata=0x1234_5678.
- Write 0x2000_0004, wdata 0xCAFE_F00D, wstrb 4'b0011, slave2 ready after 3 cycles -> s_valid=4'b0100 for T+1..T+3, s_wstrb=4'b0011, m_ready at T+3.
- Read unmapped 0x8000_0000 -> m_ready and err_pulse at T+1, m_rdata=0xBADA_DD00, err_addr=0x8000_0000, err_count=1.
- TIMEOUT_CYCLES=8, slave1 never ready -> s_valid[1] high exactly 8 cycles, m_ready and err_pulse at T+9; same test with s_ready asserted on the 8th cycle -> normal completion, err_count unchanged.
- Overlapping masks (slave0 and slave3 both hit) -> slave0 selected; resetn low while in ACCESS -> s_valid=0 next edge, no m_ready, err_count=0.
- Force 65,536 errors -> err_count saturates at 0xFFFF.

Source files
------------

// File: rtl/soc_bus_fabric.sv
// soc_bus_fabric: CPU memory-port fabric with address decode, a single
// outstanding access, per-access timeout and an error responder so that
// unmapped or hung accesses still complete.
module soc_bus_fabric #(
  parameter int                      NUM_SLAVES     = 4,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE    = {32'h3000_0000, 32'h2000_0000,
                                                      32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK    = {4{32'hFFFF_0000}},
  parameter int                      TIMEOUT_CYCLES = 255,
  parameter logic [31:0]             ERR_RDATA      = 32'hBADA_DD00,
  // Width of the saturating error counter.
  parameter int                      ERR_CNT_W      = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       m_valid,
  input  logic                       m_instr,
  input  logic [31:0]                m_addr,
  input  logic [31:0]                m_wdata,
  input  logic [3:0]                 m_wstrb,
  output logic                       m_ready,
  output logic [31:0]                m_rdata,
  output logic [NUM_SLAVES-1:0]      s_valid,
  output logic [31:0]                s_addr,
  output logic [31:0]                s_wdata,
  output logic [3:0]                 s_wstrb,
  input  logic [NUM_SLAVES*32-1:0]   s_rdata,
  input  logic [NUM_SLAVES-1:0]      s_ready,
  output logic                       err_pulse,
  output logic [31:0]                err_addr,
  output logic [ERR_CNT_W-1:0]       err_count
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] ERROR  = 2'd2;
  localparam logic [1:0] GAP    = 2'd3;

  logic [1:0]       state, state_nxt;
  logic [SEL_W-1:0] sel, hit_idx;
  logic             hit;
  logic [31:0]      cnt;
  logic             sel_ready;
  logic [31:0]      sel_rdata;
  logic             timeout_hit;
  logic             unused_instr;

  assign unused_instr = m_instr;

  assign s_addr  = m_addr;
  assign s_wdata = m_wdata;
  assign s_wstrb = m_wstrb;

  // Address decode; scanning downward lets the lowest matching index win.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((m_addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
        hit     = 1'b1;
        hit_idx = SEL_W'(i);
      end
    end
  end

  // Mux the selected slave's ready/rdata and form the one-hot request.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    s_valid   = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_ready  = s_ready[i];
        sel_rdata  = s_rdata[32*i +: 32];
        s_valid[i] = (state == ACCESS);
      end
    end
  end

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == 32'(TIMEOUT_CYCLES - 1));

  // Next-state logic; ready beats a timeout landing in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (m_valid) state_nxt = hit ? ACCESS : ERROR;
      ACCESS: begin
        if (!m_valid)         state_nxt = IDLE;
        else if (sel_ready)   state_nxt = GAP;
        else if (timeout_hit) state_nxt = ERROR;
      end
      ERROR:   state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // CPU-side completion and read data; zero whenever no completion.
  always_comb begin
    m_ready   = 1'b0;
    m_rdata   = '0;
    err_pulse = 1'b0;
    if (state == ACCESS && m_valid && sel_ready) begin
      m_ready = 1'b1;
      m_rdata = sel_rdata;
    end else if (state == ERROR) begin
      m_ready   = 1'b1;
      err_pulse = 1'b1;
      m_rdata   = (m_wstrb == 4'b0000) ? ERR_RDATA : 32'h0;
    end
  end

  // State, latched target and access-age counter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      sel   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        sel <= hit_idx;
        cnt <= '0;
      end else if (state == ACCESS) begin
        cnt <= cnt + 32'd1;
      end
    end
  end

  // Error log: address of last failure and a saturating failure count.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      err_addr  <= '0;
      err_count <= '0;
    end else if (state == ERROR) begin
      err_addr <= m_addr;
      if (err_count != {ERR_CNT_W{1'b1}}) err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_soc_bus_fabric.sv
// tb_soc_bus_fabric: scoreboard-based bench; expected completions are queued
// when a request is driven and checked by a monitor when m_ready appears.
module tb_soc_bus_fabric;

  typedef struct packed {
    logic        err;
    logic [31:0] rd;
  } exp_t;

  logic         clk = 1'b0;
  logic         resetn;
  logic         m_valid, m_instr;
  logic [31:0]  m_addr, m_wdata;
  logic [3:0]   m_wstrb;
  logic         m_ready;
  logic [31:0]  m_rdata;
  logic [3:0]   s_valid;
  logic [31:0]  s_addr, s_wdata;
  logic [3:0]   s_wstrb;
  logic [127:0] s_rdata;
  logic [3:0]   s_ready;
  logic         err_pulse;
  logic [31:0]  err_addr;
  logic [15:0]  err_count;

  // Small instance with a narrow error counter for the saturation check.
  logic         sat_valid;
  logic         sat_ready;
  logic [31:0]  sat_rdata, sat_saddr, sat_swdata, sat_erraddr;
  logic [0:0]   sat_svalid;
  logic [3:0]   sat_swstrb;
  logic         sat_err;
  logic [3:0]   sat_cnt;

  int tests = 0;
  int fails = 0;
  exp_t sb[$];
  int exp_err_cnt = 0;
  logic [31:0] exp_err_addr = '0;

  logic [31:0] rdat [4];
  int          lat  [4];
  int          vcnt [4];
  logic [3:0]  stray;

  always #5 clk = ~clk;

  soc_bus_fabric #(
    .NUM_SLAVES(4),
    .SLAVE_BASE({32'h0000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
    .SLAVE_MASK({32'hF000_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000}),
    .TIMEOUT_CYCLES(8),
    .ERR_RDATA(32'hBADA_DD00)
  ) dut (
    .clk(clk), .resetn(resetn), .m_valid(m_valid), .m_instr(m_instr),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ready(m_ready), .m_rdata(m_rdata), .s_valid(s_valid),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_rdata(s_rdata), .s_ready(s_ready), .err_pulse(err_pulse),
    .err_addr(err_addr), .err_count(err_count)
  );

  soc_bus_fabric #(
    .NUM_SLAVES(1), .SLAVE_BASE(32'h0000_0000), .SLAVE_MASK(32'hFFFF_0000),
    .TIMEOUT_CYCLES(8), .ERR_RDATA(32'hBADA_DD00), .ERR_CNT_W(4)
  ) u_sat (
    .clk(clk), .resetn(resetn), .m_valid(sat_valid), .m_instr(1'b0),
    .m_addr(32'h8000_0000), .m_wdata(32'h0), .m_wstrb(4'b0000),
    .m_ready(sat_ready), .m_rdata(sat_rdata), .s_valid(sat_svalid),
    .s_addr(sat_saddr), .s_wdata(sat_swdata), .s_wstrb(sat_swstrb),
    .s_rdata(32'h0), .s_ready(1'b0), .err_pulse(sat_err),
    .err_addr(sat_erraddr), .err_count(sat_cnt)
  );

  // Slave models: slave i readies on its lat[i]-th request cycle (0 = never).
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      s_rdata[32*i +: 32] = rdat[i];
      s_ready[i] = stray[i] | (s_valid[i] && lat[i] != 0 && (vcnt[i] + 1 == lat[i]));
    end
  end

  always @(posedge clk)
    for (int i = 0; i < 4; i++) vcnt[i] <= s_valid[i] ? vcnt[i] + 1 : 0;

  // Monitor: every completion must match the oldest queued expectation.
  always @(negedge clk) begin
    if (m_ready === 1'b1) begin
      exp_t e;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_m_ready: got m_ready=1 with nothing outstanding");
      end else begin
        e = sb.pop_front();
        if (m_rdata !== e.rd || err_pulse !== e.err) begin
          fails++;
          $display("FAIL completion: got rdata=%h err=%b exp rdata=%h err=%b",
                   m_rdata, err_pulse, e.rd, e.err);
        end
      end
    end else if (m_ready === 1'b0 && (m_rdata !== 32'h0 || err_pulse !== 1'b0)) begin
      tests++;
      fails++;
      $display("FAIL idle_outputs: got rdata=%h err=%b exp 0", m_rdata, err_pulse);
    end
  end

  // Drive one access and check per-cycle s_valid, latency and the error log.
  task automatic access(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input int sv_slave,
                        input int sv_cycles, input int exp_lat, input bit exp_err,
                        input logic [31:0] exp_rd, input bit hold);
    int got = 0;
    logic [3:0] exp_sv;
    sb.push_back('{err: exp_err, rd: exp_rd});
    @(negedge clk);
    m_valid = 1'b1; m_addr = addr; m_wdata = wdata; m_wstrb = wstrb;
    for (int k = 1; k <= 40 && got == 0; k++) begin
      @(posedge clk); @(negedge clk);
      exp_sv = (k <= sv_cycles) ? (4'b0001 << sv_slave) : 4'b0000;
      tests++;
      if (s_valid !== exp_sv) begin
        fails++;
        $display("FAIL s_valid@%h cyc%0d: got %b exp %b", addr, k, s_valid, exp_sv);
      end
      if (k == 1) begin
        tests++;
        if (s_addr !== addr || s_wdata !== wdata || s_wstrb !== wstrb) begin
          fails++;
          $display("FAIL broadcast: got %h/%h/%b exp %h/%h/%b",
                   s_addr, s_wdata, s_wstrb, addr, wdata, wstrb);
        end
      end
      if (m_ready === 1'b1) got = k;
    end
    tests++;
    if (got != exp_lat) begin
      fails++;
      $display("FAIL latency@%h: got %0d exp %0d (0 = no m_ready in budget)", addr, got, exp_lat);
    end
    if (exp_err) begin
      exp_err_addr = addr;
      if (exp_err_cnt < 16'hFFFF) exp_err_cnt++;
    end
    @(posedge clk); #1;
    if (!hold) m_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (s_valid !== 4'b0 || m_ready !== 1'b0 || err_count !== 16'(exp_err_cnt)
        || err_addr !== exp_err_addr) begin
      fails++;
      $display("FAIL gap@%h: got sv=%b rdy=%b cnt=%0d eaddr=%h exp sv=0 rdy=0 cnt=%0d eaddr=%h",
               addr, s_valid, m_ready, err_count, err_addr, exp_err_cnt, exp_err_addr);
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0; m_valid = 1'b0; m_instr = 1'b0; m_addr = '0; m_wdata = '0;
    m_wstrb = '0; stray = '0; sat_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin lat[i] = 1; rdat[i] = 32'h0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (s_valid !== 4'b0 || m_ready !== 1'b0 || m_rdata !== 32'h0 || err_pulse !== 1'b0
        || err_addr !== 32'h0 || err_count !== 16'h0) begin
      fails++;
      $display("FAIL reset: got sv=%b rdy=%b rd=%h ep=%b ea=%h ec=%0d exp all 0",
               s_valid, m_ready, m_rdata, err_pulse, err_addr, err_count);
    end
    resetn = 1'b1;
    @(posedge clk);
  endtask

  task automatic test_read_zero_wait();
    rdat[0] = 32'h1234_5678; lat[0] = 1;
    // 0x10 also hits slave3's wide window; slave0 must win.
    access(32'h0000_0010, 32'h0, 4'b0000, 0, 1, 1, 1'b0, 32'h1234_5678, 1'b0);
  endtask

  task automatic test_write_wait();
    rdat[2] = 32'h0000_2222; lat[2] = 3;
    stray = 4'b1011;  // unselected slaves shouting ready must be ignored
    access(32'h2000_0004, 32'hCAFE_F00D, 4'b0011, 2, 3, 3, 1'b0, 32'h0000_2222, 1'b0);
    stray = 4'b0000;
  endtask

  task automatic test_unmapped();
    access(32'h8000_0000, 32'h0, 4'b0000, 0, 0, 1, 1'b1, 32'hBADA_DD00, 1'b0);
    access(32'h9000_0000, 32'h5555_AAAA, 4'b1111, 0, 0, 1, 1'b1, 32'h0, 1'b0);
  endtask

  task automatic test_timeout();
    rdat[1] = 32'h1111_0001;
    lat[1] = 0;
    access(32'h1000_0000, 32'h0, 4'b0000, 1, 8, 9, 1'b1, 32'hBADA_DD00, 1'b0);
    lat[1] = 8;  // ready coincides with expiry: ready wins
    access(32'h1000_0020, 32'h0, 4'b0000, 1, 8, 8, 1'b0, 32'h1111_0001, 1'b0);
  endtask

  task automatic test_overlap_slave3();
    rdat[3] = 32'h3333_0003; lat[3] = 2;
    access(32'h0001_0000, 32'h0, 4'b0000, 3, 2, 2, 1'b0, 32'h3333_0003, 1'b0);
  endtask

  task automatic test_back_to_back();
    rdat[0] = 32'h0A0A_0A0A; lat[0] = 1; lat[2] = 2;
    // Request held through GAP: must not reissue until the following IDLE.
    access(32'h0000_0040, 32'h0, 4'b0000, 0, 1, 1, 1'b0, 32'h0A0A_0A0A, 1'b1);
    access(32'h2000_0008, 32'h0, 4'b0000, 2, 2, 2, 1'b0, 32'h0000_2222, 1'b1);
    access(32'h0000_0044, 32'h0, 4'b0000, 0, 1, 1, 1'b0, 32'h0A0A_0A0A, 1'b0);
  endtask

  task automatic test_abort();
    lat[1] = 0;
    @(negedge clk);
    m_valid = 1'b1; m_addr = 32'h1000_0100; m_wstrb = 4'b0000;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    tests++;
    if (s_valid !== 4'b0010) begin
      fails++; $display("FAIL abort_pre: got %b exp 0010", s_valid);
    end
    m_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    tests++;
    if (s_valid !== 4'b0000) begin
      fails++; $display("FAIL abort_drop: got %b exp 0000", s_valid);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (err_count !== 16'(exp_err_cnt)) begin
      fails++; $display("FAIL abort_errcnt: got %0d exp %0d", err_count, exp_err_cnt);
    end
  endtask

  task automatic test_reset_mid_access();
    lat[1] = 0;
    @(negedge clk);
    m_valid = 1'b1; m_addr = 32'h1000_0200; m_wstrb = 4'b0000;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    resetn = 1'b0;
    @(posedge clk); #1 m_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (s_valid !== 4'b0 || m_ready !== 1'b0 || err_count !== 16'h0 || err_addr !== 32'h0) begin
      fails++;
      $display("FAIL reset_mid: got sv=%b rdy=%b ec=%0d ea=%h exp 0", s_valid, m_ready,
               err_count, err_addr);
    end
    exp_err_cnt = 0; exp_err_addr = '0;
    resetn = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_saturation();
    int pulses = 0;
    @(negedge clk);
    sat_valid = 1'b1;
    for (int k = 0; k < 42; k++) begin
      @(posedge clk); @(negedge clk);
      if (sat_err === 1'b1) pulses++;
    end
    tests++;
    if (sat_cnt !== 4'd14 || pulses != 14) begin
      fails++; $display("FAIL sat_mid: got cnt=%0d pulses=%0d exp 14/14", sat_cnt, pulses);
    end
    for (int k = 0; k < 18; k++) begin
      @(posedge clk); @(negedge clk);
      if (sat_err === 1'b1) pulses++;
    end
    tests++;
    if (sat_cnt !== 4'hF || pulses != 20) begin
      fails++; $display("FAIL sat_end: got cnt=%0d pulses=%0d exp 15/20", sat_cnt, pulses);
    end
    sat_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_wait();
    test_unmapped();
    test_timeout();
    test_overlap_slave3();
    test_back_to_back();
    test_abort();
    test_reset_mid_access();
    test_saturation();
    repeat (4) @(posedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++; $display("FAIL scoreboard_drain: got %0d outstanding exp 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
